updown_counter_n: RTL and testbench

- Parametrised up/down counter; successor to the fixed 3-bit up/down counter.
- Adds programmable modulus, parallel load, three terminal-count modes (wrap, saturate, one-shot), carry/borrow pulse, sticky overflow flag and a halt state machine.
- Used as the counting primitive for timers and event counters in the design.

---
 rtl/updown_counter_n.sv | 140 ++++++++++++++
 tb/tb_updown_counter_n.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// -----------------------------------------------------------------------------
// updown_counter_n
//
// Parametrised up/down counter. It supports a programmable modulus, parallel
// load, and three terminal-count modes: wrap, saturate and one-shot. It also
// provides a registered carry/borrow pulse, a sticky overflow flag, and a
// RUN/HALT state machine for one-shot operation.
//
// Parameters
//   WIDTH       counter width in bits (2..32)
//   RESET_VAL   value loaded into q on reset (must fit in WIDTH bits)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   count        count enable, one step per cycle while high
//   inc          direction: 1 = up, 0 = down
//   load         synchronous parallel load strobe (highest priority)
//   load_val     value to load; clamped to mod_val
//   mod_val      inclusive upper bound of q; sampled live
//   mode         00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   clear_flags  clears ovf and leaves HALT
//   q            registered count value
//   cout         one-cycle carry/borrow pulse, registered
//   tc           combinational terminal count for the current direction
//   ovf          sticky overflow/underflow flag
//   done         high while the state machine is in HALT
// -----------------------------------------------------------------------------
module updown_counter_n #(
  parameter int          WIDTH     = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [1:0]       mode,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] q_next;
  logic             cout_next;
  logic             ovf_next;
  logic             up_term;
  logic             dn_term;
  logic             step;
  logic             term;
  logic             hold_at_bound;

  // The up-terminal test uses >= rather than ==. This catches the case where
  // mod_val has been lowered below the current q.
  assign up_term = (q >= mod_val);
  assign dn_term = (q == '0);
  assign tc      = (inc & up_term) | (~inc & dn_term);

  // Count is ignored entirely while halted.
  assign step = count & (state == ST_RUN);

  // In saturate and one-shot modes, a terminal step holds at the bound.
  // Wrap mode (and the reserved encoding) jumps to the opposite end.
  assign hold_at_bound = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned (no inferred latch).
    q_next     = q;
    state_next = state;
    term       = 1'b0;

    if (load) begin
      q_next     = (load_val > mod_val) ? mod_val : load_val;
      state_next = ST_RUN;
    end else begin
      if (step) begin
        if (inc) begin
          if (up_term) begin
            term   = 1'b1;
            q_next = hold_at_bound ? mod_val : '0;
          end else begin
            q_next = q + WIDTH'(1);
          end
        end else begin
          if (dn_term) begin
            term   = 1'b1;
            q_next = hold_at_bound ? '0 : mod_val;
          end else begin
            q_next = q - WIDTH'(1);
          end
        end
      end

      if (clear_flags) begin
        state_next = ST_RUN;
      end
      // A one-shot terminal step outranks a simultaneous clear, matching the
      // set-wins rule used for ovf.
      if (term && (mode == MODE_ONESHOT)) begin
        state_next = ST_HALT;
      end
    end

    cout_next = term;
    ovf_next  = term | (ovf & ~clear_flags);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= WIDTH'(RESET_VAL);
      cout  <= 1'b0;
      ovf   <= 1'b0;
      state <= ST_RUN;
    end else begin
      q     <= q_next;
      cout  <= cout_next;
      ovf   <= ovf_next;
      state <= state_next;
    end
  end

  assign done = (state == ST_HALT);

endmodule

// File: tb/tb_updown_counter_n.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_n
//
// Self-checking bench for updown_counter_n (WIDTH=3).
//
// Two instances share all inputs:
//   - RESET_VAL=0: the main checked instance.
//   - RESET_VAL=2: used to observe a non-zero reset value.
//
// The bench is organised in three parts:
//   - Directed vectors from a table.
//   - A hand-written asynchronous reset sequence.
//   - Randomized cycles checked against an integer reference model.
// -----------------------------------------------------------------------------
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       count;
  logic       inc;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] mod_val;
  logic [1:0] mode;
  logic       clear_flags;

  logic [2:0] q0, q2;
  logic       cout0, tc0, ovf0, done0;
  logic       cout2, tc2, ovf2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(3), .RESET_VAL(0)) dut0 (
    .clk(clk), .reset(reset), .count(count), .inc(inc), .load(load),
    .load_val(load_val), .mod_val(mod_val), .mode(mode),
    .clear_flags(clear_flags), .q(q0), .cout(cout0), .tc(tc0), .ovf(ovf0),
    .done(done0)
  );

  updown_counter_n #(.WIDTH(3), .RESET_VAL(2)) dut2 (
    .clk(clk), .reset(reset), .count(count), .inc(inc), .load(load),
    .load_val(load_val), .mod_val(mod_val), .mode(mode),
    .clear_flags(clear_flags), .q(q2), .cout(cout2), .tc(tc2), .ovf(ovf2),
    .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table. Expected values are after the clock edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    bit         ld, cnt, up, clr;
    logic [2:0] lv, mv;
    logic [1:0] md;
    logic [2:0] eq;
    bit         ec, eo, ed, et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input bit ld, cnt, up, clr,
                              input int lv, mv, md, eq,
                              input bit ec, eo, ed, et);
    vec_t v;
    v.name = name;
    v.ld   = ld;
    v.cnt  = cnt;
    v.up   = up;
    v.clr  = clr;
    v.lv   = 3'(lv);
    v.mv   = 3'(mv);
    v.md   = 2'(md);
    v.eq   = 3'(eq);
    v.ec   = ec;
    v.eo   = eo;
    v.ed   = ed;
    v.et   = et;
    return v;
  endfunction

  task automatic drive(input bit ld, cnt, up, clr, input int lv, mv, md);
    load        = ld;
    count       = cnt;
    inc         = up;
    clear_flags = clr;
    load_val    = 3'(lv);
    mod_val     = 3'(mv);
    mode        = 2'(md);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: integer arithmetic straight from the counting rules.
  // ---------------------------------------------------------------------------
  int m_q;
  bit m_cout, m_ovf, m_halt;

  task automatic model_step(input bit ld, cnt, up, clr, input int lv, mv, md);
    bit terminal = 0;
    if (ld) begin
      m_q    = (lv < mv) ? lv : mv;
      m_halt = 0;
      if (clr) m_ovf = 0;
    end else begin
      if (cnt && !m_halt) begin
        if (up) begin
          if (m_q < mv) begin
            m_q = m_q + 1;
          end else begin
            terminal = 1;
            m_q = (md == 1 || md == 2) ? mv : 0;
          end
        end else begin
          if (m_q > 0) begin
            m_q = m_q - 1;
          end else begin
            terminal = 1;
            m_q = (md == 1 || md == 2) ? 0 : mv;
          end
        end
      end
      if (clr) begin
        m_ovf  = 0;
        m_halt = 0;
      end
      if (terminal) m_ovf = 1;
      if (terminal && md == 2) m_halt = 1;
    end
    m_cout = terminal;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    drive(0, 0, 1, 0, 0, 7, 0);
    #1;
    check("reset_q_rv0", 32'(q0), 32'd0);
    check("reset_q_rv2", 32'(q2), 32'd2);
    check("reset_flags", 32'({cout0, ovf0, done0}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- build table ----------------
    // Plan 1: wrap up through 7 -> 0 -> 1.
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk("t1_wrap_up", 0, 1, 1, 0, 0, 7, 0,
                        k % 8, k == 8, k >= 8, 0, (k % 8) == 7));

    // Plan 2: load 2, count down with wrap to mod_val 5.
    vecs.push_back(mk("t2_load",  1, 0, 0, 1, 2, 5, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk("t2_dn_1",  0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t2_dn_0",  0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t2_wrap5", 0, 1, 0, 0, 0, 5, 0, 5, 1, 1, 0, 0));
    vecs.push_back(mk("t2_dn_4",  0, 1, 0, 0, 0, 5, 0, 4, 0, 1, 0, 0));

    // Plan 3: saturate at 6; cout pulses each step at the bound.
    vecs.push_back(mk("t3_load",  1, 0, 1, 1, 5, 6, 1, 5, 0, 0, 0, 0));
    vecs.push_back(mk("t3_up6",   0, 1, 1, 0, 0, 6, 1, 6, 0, 0, 0, 1));
    vecs.push_back(mk("t3_sat_a", 0, 1, 1, 0, 0, 6, 1, 6, 1, 1, 0, 1));
    vecs.push_back(mk("t3_sat_b", 0, 1, 1, 0, 0, 6, 1, 6, 1, 1, 0, 1));
    vecs.push_back(mk("t3_clear", 0, 0, 1, 1, 0, 6, 1, 6, 0, 0, 0, 1));

    // Plan 4: one-shot to 4, halt, then resume by load.
    vecs.push_back(mk("t4_load0", 1, 0, 1, 1, 0, 4, 2, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk("t4_oneshot", 0, 1, 1, 0, 0, 4, 2,
                        (k < 4) ? k : 4, k == 5, k >= 5, k >= 5, k >= 4));
    vecs.push_back(mk("t4_resume", 1, 1, 1, 0, 1, 4, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk("t4_run",    0, 1, 1, 0, 0, 4, 2, 2, 0, 1, 0, 0));

    // HALT left via clear_flags: count is ignored on that cycle.
    vecs.push_back(mk("t4_load4",  1, 0, 1, 0, 4, 4, 2, 4, 0, 1, 0, 1));
    vecs.push_back(mk("t4_halt",   0, 1, 1, 0, 0, 4, 2, 4, 1, 1, 1, 1));
    vecs.push_back(mk("t4_clrhlt", 0, 1, 1, 1, 0, 4, 2, 4, 0, 0, 0, 1));
    vecs.push_back(mk("t4_rehalt", 0, 1, 1, 0, 0, 4, 2, 4, 1, 1, 1, 1));

    // Plan 5: load clamps to mod_val; load beats count.
    vecs.push_back(mk("t5_clamp",   1, 0, 1, 0, 7, 3, 0, 3, 0, 1, 0, 1));
    vecs.push_back(mk("t5_ld_wins", 1, 1, 1, 0, 1, 3, 0, 1, 0, 1, 0, 0));

    // Plan 6b: clear and terminal step together; set wins.
    vecs.push_back(mk("t6_load3",   1, 0, 1, 1, 3, 3, 0, 3, 0, 0, 0, 1));
    vecs.push_back(mk("t6_set_win", 0, 1, 1, 1, 0, 3, 0, 0, 1, 1, 0, 0));

    // mod_val = 0: every enabled step is terminal.
    vecs.push_back(mk("mod0_up", 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk("mod0_dn", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));

    // mod_val lowered below q.
    vecs.push_back(mk("low_load",   1, 0, 0, 1, 6, 7, 0, 6, 0, 0, 0, 0));
    vecs.push_back(mk("low_dn",     0, 1, 0, 0, 0, 2, 1, 5, 0, 0, 0, 0));
    vecs.push_back(mk("low_up_sat", 0, 1, 1, 0, 0, 2, 1, 2, 1, 1, 0, 1));
    vecs.push_back(mk("low_load2",  1, 0, 1, 0, 6, 7, 0, 6, 0, 1, 0, 0));
    vecs.push_back(mk("low_up_wrp", 0, 1, 1, 0, 0, 2, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("hold",       0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0));

    // ---------------- apply table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ld, vecs[i].cnt, vecs[i].up, vecs[i].clr,
            int'(vecs[i].lv), int'(vecs[i].mv), int'(vecs[i].md));
      @(posedge clk);
      #1;
      check(vecs[i].name, 32'({q0, cout0, ovf0, done0, tc0}),
            32'({vecs[i].eq, vecs[i].ec, vecs[i].eo, vecs[i].ed, vecs[i].et}));
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    @(negedge clk);
    drive(1, 0, 1, 1, 6, 6, 2);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 6, 2);
    @(posedge clk);
    #1;
    check("pre_reset_state", 32'({q2, cout2, ovf2, done2}), 32'({3'd6, 3'b111}));
    #3;
    reset = 1'b1;
    #1;  // still well before the next rising edge
    check("async_reset_rv2", 32'({q2, cout2, ovf2, done2}), 32'({3'd2, 3'b000}));
    check("async_reset_rv0", 32'(q0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 1, 0, 0, 7, 0);

    // ---------------- randomized against the model ----------------
    m_q    = 0;
    m_cout = 0;
    m_ovf  = 0;
    m_halt = 0;
    for (int n = 0; n < 400; n++) begin
      bit ld, cnt, up, clr;
      int lv, mv, md;
      bit exp_tc;
      @(negedge clk);
      ld  = ($urandom_range(7) == 0);
      clr = ($urandom_range(7) == 0);
      cnt = ($urandom_range(3) != 0);
      up  = 1'($urandom_range(1));
      lv  = int'($urandom_range(7));
      mv  = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : 5;
      md  = int'($urandom_range(3));
      drive(ld, cnt, up, clr, lv, mv, md);
      model_step(ld, cnt, up, clr, lv, mv, md);
      exp_tc = up ? (m_q >= mv) : (m_q == 0);
      @(posedge clk);
      #1;
      check("random", 32'({q0, cout0, ovf0, done0, tc0}),
            32'({3'(m_q), m_cout, m_ovf, m_halt, exp_tc}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
